// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned NxN multiplier using shift-and-add around a ripple-carry adder
module adderNbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  input  logic         carry_in,
  output logic [N-1:0] result,
  output logic         carry_out
);
  logic [N:0] c;
  assign c[0] = carry_in;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign result[i] = operand_a[i] ^ operand_b[i] ^ c[i];
    assign c[i+1]    = (operand_a[i] & operand_b[i]) | (c[i] & (operand_a[i] ^ operand_b[i]));
  end
  assign carry_out = c[N];
endmodule

module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;
  logic [N-1:0] a_reg, b_reg, acc_hi, acc_lo, sum;
  logic [CW-1:0] count;
  logic carry;
  logic last;
  logic [2*N-1:0] shifted;
  logic unused_lsb;
  adderNbit #(.N(N)) u_add (
    .operand_a(acc_hi),
    .operand_b(b_reg[0] ? a_reg : '0),
    .carry_in (1'b0),
    .result   (sum),
    .carry_out(carry)
  );
  // The adder's carry enters the accumulator MSB, so no product bit is lost; the shifted-out LSB is discarded.
  assign shifted    = {carry, sum, acc_lo[N-1:1]};
  assign unused_lsb = acc_lo[0];
  assign last       = count == CW'(N - 1);
  assign busy       = state == CALC;
  assign done       = state == DONE;
  // State register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_next;
  // Next-state: IDLE waits for start, CALC runs N iterations, DONE lasts one cycle
  always_comb begin
    state_next = state;
    if (state == IDLE && start) state_next = CALC;
    else if (state == CALC && last) state_next = DONE;
    else if (state == DONE) state_next = IDLE;
  end
  // Datapath: load operands on accepted start, shift-add each CALC cycle, capture product on the last iteration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
      product <= '0;
    end else if (state == IDLE && start) begin
      a_reg  <= multiplicand;
      b_reg  <= multiplier;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else if (state == CALC) begin
      {acc_hi, acc_lo} <= shifted;
      b_reg            <= b_reg >> 1;
      count            <= count + 1'b1;
      if (last) product <= shifted;
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: random and directed checks of N=4 and N=8 multipliers against a cycle-level reference model
module tb_shift_add_multiplier;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [1:0] st;
  logic [1:0][7:0] ma, mb;
  logic busy4, done4, busy8, done8;
  logic [7:0] prod4;
  logic [15:0] prod8;
  logic [1:0] bz, dn;
  logic [1:0][15:0] pr;
  int checks = 0, errors = 0;
  bit on = 0;
  int ph[2];
  logic [15:0] ea[2], ep[2];
  shift_add_multiplier #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .multiplicand(ma[0][3:0]), .multiplier(mb[0][3:0]),
    .busy(busy4), .done(done4), .product(prod4)
  );
  shift_add_multiplier #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .multiplicand(ma[1]), .multiplier(mb[1]),
    .busy(busy8), .done(done8), .product(prod8)
  );
  assign bz = {busy8, busy4};
  assign dn = {done8, done4};
  assign pr[0] = {8'h00, prod4};
  assign pr[1] = prod8;
  function automatic int nw(int d);
    return d != 0 ? 8 : 4;
  endfunction
  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask
  // Reference: ph is cycles since acceptance (-1 idle); product is A*B, published N edges after acceptance
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        ph[d] <= -1;
        ep[d] <= '0;
      end else if (ph[d] < 0) begin
        if (st[d]) begin
          ph[d] <= 0;
          ea[d] <= d != 0 ? 16'(ma[d]) * 16'(mb[d]) : 16'(ma[d][3:0]) * 16'(mb[d][3:0]);
        end
      end else if (ph[d] == nw(d)) ph[d] <= -1;
      else begin
        ph[d] <= ph[d] + 1;
        if (ph[d] == nw(d) - 1) ep[d] <= ea[d];
      end
    end
  always @(negedge clk)
    if (on)
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy_n%0d", nw(d)), 16'(bz[d]), 16'(ph[d] >= 0 && ph[d] < nw(d)));
        chk($sformatf("done_n%0d", nw(d)), 16'(dn[d]), 16'(ph[d] == nw(d)));
        chk($sformatf("product_n%0d", nw(d)), pr[d], ep[d]);
      end
  task automatic go(int d, logic [7:0] a, logic [7:0] b);
    @(negedge clk);
    st[d] = 1;
    ma[d] = a;
    mb[d] = b;
    @(negedge clk);
    st[d] = 0;
  endtask
  task automatic wait_done(int d, output int cyc, output int bc);
    cyc = 1;
    bc = int'(bz[d]);
    while (!dn[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bc += int'(bz[d]);
    end
    if (!dn[d]) chk("done_timeout", 16'(dn[d]), 16'd1);
  endtask
  initial begin
    int cyc, bc;
    rst_n = 0;
    st = '0;
    ma = '0;
    mb = '0;
    ph[0] = -1;
    ph[1] = -1;
    repeat (2) @(negedge clk);
    on = 1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", 16'(bz[d]), 16'd0);
      chk("reset_done", 16'(dn[d]), 16'd0);
      chk("reset_product", pr[d], 16'd0);
    end
    rst_n = 1;
    go(0, 0, 0);
    wait_done(0, cyc, bc);
    chk("zero_latency", 16'(cyc), 16'd5);
    chk("zero_busy_cycles", 16'(bc), 16'd4);
    chk("zero_product", pr[0], 16'd0);
    go(0, 15, 15);
    wait_done(0, cyc, bc);
    chk("ff_product", pr[0], 16'd225);
    @(negedge clk);
    chk("ff_done_width", 16'(dn[0]), 16'd0);
    @(negedge clk);
    st[0] = 1;
    ma[0] = 13;
    mb[0] = 11;
    @(negedge clk);
    ma[0] = 2;
    mb[0] = 3;
    @(negedge clk);
    ma[0] = 7;
    mb[0] = 9;
    @(negedge clk);
    st[0] = 0;
    wait_done(0, cyc, bc);
    chk("hold_product", pr[0], 16'd143);
    repeat (3) begin
      @(negedge clk);
      chk("hold_single_op", 16'(bz[0]), 16'd0);
    end
    go(0, 3, 5);
    wait_done(0, cyc, bc);
    chk("p15", pr[0], 16'd15);
    go(0, 0, 9);
    chk("p15_held", pr[0], 16'd15);
    wait_done(0, cyc, bc);
    chk("p0_after", pr[0], 16'd0);
    go(0, 12, 7);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_busy", 16'(bz[0]), 16'd0);
    chk("abort_product", pr[0], 16'd0);
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", 16'(dn[0]), 16'd0);
    end
    go(0, 12, 7);
    wait_done(0, cyc, bc);
    chk("p84", pr[0], 16'd84);
    go(1, 255, 255);
    wait_done(1, cyc, bc);
    chk("p65025", pr[1], 16'd65025);
    chk("n8_latency", 16'(cyc), 16'd9);
    go(1, 128, 2);
    wait_done(1, cyc, bc);
    chk("p256", pr[1], 16'd256);
    for (int k = 0; k < 500; k++) begin
      go(1, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        ma[1] = 8'($urandom);
        mb[1] = 8'($urandom);
      end
      wait_done(1, cyc, bc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
